// File: rtl/struct_deserializer.sv
// struct_deserializer
//
// Receive end of the byte-serial struct link. Six bytes arrive on an 8-bit
// valid/ready stream and are reassembled into the 41-bit record
// {flag, value[31:0], tag[7:0]}, then presented unpacked on a valid/ready
// output.
//
// Wire order: byte0 = tag, bytes1..4 = value (LSB first),
// byte5 = {7'b0, flag}. Nonzero padding in byte5 drops the record.
//
// Ports:
//   clk          single clock, all state changes on posedge
//   reset        asynchronous, active-low; clears all state immediately
//   in_valid     byte offered
//   in_data      byte payload
//   in_ready     byte accepted on in_valid && in_ready at posedge
//   out_valid    unpacked record available
//   out_ready    consumer takes the record on out_valid && out_ready
//   out_flag     record bit 40
//   out_value    record bits 39:8
//   out_tag      record bits 7:0
//   err_framing  one-cycle pulse: padding bits nonzero, record dropped
//   err_timeout  one-cycle pulse: partial record abandoned
//
// Parameter:
//   TIMEOUT_CYCLES  idle cycles tolerated inside a partial record (1..255)

module struct_deserializer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_flag,
    output logic [31:0] out_value,
    output logic [7:0]  out_tag,
    output logic        err_framing,
    output logic        err_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    // The timeout fires on the idle edge that would bring the gap count to
    // TIMEOUT_CYCLES, so the compare is against one less than that.
    localparam logic [7:0] GAP_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [2:0]  count;
    logic [7:0]  gap;
    logic [7:0]  tag_buf;
    logic [31:0] value_buf;
    logic        accept;

    // in_ready is combinational from the state so it drops with reset and
    // rises in the same cycle the handshake returns the block to IDLE.
    assign in_ready = reset && (state != HOLD);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= 3'd0;
            gap         <= 8'd0;
            tag_buf     <= 8'd0;
            value_buf   <= 32'd0;
            out_valid   <= 1'b0;
            out_flag    <= 1'b0;
            out_value   <= 32'd0;
            out_tag     <= 8'd0;
            err_framing <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            err_framing <= 1'b0;
            err_timeout <= 1'b0;

            case (state)
                IDLE: begin
                    gap <= 8'd0;
                    if (accept) begin
                        tag_buf <= in_data;
                        count   <= 3'd1;
                        state   <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (accept) begin
                        // An accepted byte always beats a pending timeout.
                        gap   <= 8'd0;
                        count <= count + 3'd1;
                        case (count)
                            3'd1: value_buf[7:0]   <= in_data;
                            3'd2: value_buf[15:8]  <= in_data;
                            3'd3: value_buf[23:16] <= in_data;
                            3'd4: value_buf[31:24] <= in_data;
                            default: begin
                                count <= 3'd0;
                                if (in_data[7:1] == 7'd0) begin
                                    out_flag  <= in_data[0];
                                    out_value <= value_buf;
                                    out_tag   <= tag_buf;
                                    out_valid <= 1'b1;
                                    state     <= HOLD;
                                end else begin
                                    err_framing <= 1'b1;
                                    state       <= IDLE;
                                end
                            end
                        endcase
                    end else if (gap == GAP_LAST) begin
                        err_timeout <= 1'b1;
                        gap         <= 8'd0;
                        count       <= 3'd0;
                        state       <= IDLE;
                    end else begin
                        gap <= gap + 8'd1;
                    end
                end

                HOLD: begin
                    gap <= 8'd0;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= 3'd0;
                    gap   <= 8'd0;
                end
            endcase
        end
    end

endmodule
